// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the sqrt arbiter slice: FSM state encoding,
// default operand width and the requester-index width derivation.
package sqrt_pkg;

   localparam int DEF_NBITS = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } arb_state_e;

   // Index width for n requesters; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sqrt_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ. Reusable, no state.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDXW = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [NREQ-1:0] grant_oh,
   output logic [IDXW-1:0] grant_idx,
   output logic            any
);

   always_comb begin
      int slot;
      // NOTE: every output gets a default before the loop so no path
      // through this block leaves a value unassigned (which would infer a latch).
      grant_oh  = '0;
      grant_idx = '0;
      any       = 1'b0;
      slot      = 0;
      for (int off = 0; off < NREQ; off++) begin
         slot = (int'(ptr) + off) % NREQ;
         if (!any && req[slot]) begin
            any            = 1'b1;
            grant_oh[slot] = 1'b1;
            grant_idx      = IDXW'(slot);
         end
      end
   end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one sqrt unit between NREQ valid/ready requesters, one operation at a time.
// Optional watchdog on the sqrt result: define SQRT_ARB_TIMEOUT_EN.
module sqrt_arbiter
   import sqrt_pkg::*;
#(
   parameter int NBITS       = DEF_NBITS,
   parameter int NREQ        = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [NREQ-1:0]       req_valid_i,
   input  logic [NREQ*NBITS-1:0] req_data_i,
   output logic [NREQ-1:0]       req_ready_o,
   output logic [NREQ-1:0]       rsp_valid_o,
   output logic [NBITS-1:0]      rsp_data_o,
   output logic                  rsp_err_o,
   input  logic [NREQ-1:0]       rsp_ready_i,
   output logic                  sqrt_start_o,
   output logic [NBITS-1:0]      sqrt_n_o,
   input  logic                  sqrt_busy_i,
   input  logic                  sqrt_valid_i,
   input  logic [NBITS-1:0]      sqrt_result_i
);

   localparam int IDXW = idx_width(NREQ);

   arb_state_e       state_q, state_d;
   logic [IDXW-1:0]  rr_ptr_q, grant_q, win_idx;
   logic [NREQ-1:0]  win_oh;
   logic             win_any;
   logic [NBITS-1:0] operand_q, result_q;
   logic             accept, launch, capture, timeout;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_rr (
      .req       (req_valid_i),
      .ptr       (rr_ptr_q),
      .grant_oh  (win_oh),
      .grant_idx (win_idx),
      .any       (win_any)
   );

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      launch  = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_any) begin
               accept  = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            if (!sqrt_busy_i) begin
               launch  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (sqrt_valid_i) begin
               capture = 1'b1;
               state_d = RESP;
            end else if (timeout) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i[grant_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      // NOTE: state updates use <= so every register samples pre-edge values,
      // independent of statement order inside this block.
      if (!rstn_i) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         operand_q <= '0;
         result_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            grant_q   <= win_idx;
            operand_q <= req_data_i[win_idx*NBITS +: NBITS];
            rr_ptr_q  <= (win_idx == IDXW'(NREQ - 1)) ? '0 : win_idx + IDXW'(1);
         end
         if (capture)      result_q <= sqrt_result_i;
         else if (timeout) result_q <= '0;
      end
   end

`ifdef SQRT_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] timer_q;
   logic          err_q;

   assign timeout = (state_q == WAIT) && !sqrt_valid_i && (timer_q == TW'(TIMEOUT_CYC));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         timer_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (launch)
            timer_q <= '0;
         else if (state_q == WAIT && timer_q != TW'(TIMEOUT_CYC))
            timer_q <= timer_q + TW'(1);

         if (timeout)
            err_q <= 1'b1;
         else if (state_q == RESP && rsp_ready_i[grant_q])
            err_q <= 1'b0;
      end
   end

   assign rsp_err_o = (state_q == RESP) && err_q;
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;

   assign timeout   = 1'b0;
   assign rsp_err_o = 1'b0;
`endif

   // Ready is also gated by reset so nothing is offered while rstn_i is low.
   assign req_ready_o  = (accept && rstn_i) ? win_oh : '0;
   assign sqrt_start_o = launch;
   assign sqrt_n_o     = (state_q == LAUNCH || state_q == WAIT) ? operand_q : '0;
   assign rsp_valid_o  = (state_q == RESP) ? (NREQ'(1) << grant_q) : '0;
   assign rsp_data_o   = (state_q == RESP) ? result_q : '0;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter: emulates the sqrt unit and checks
// grants/results against a round-robin + integer-sqrt reference model.
module tb_sqrt_arbiter;

   localparam int NBITS       = 5;
   localparam int NREQ        = 4;
   localparam int TIMEOUT_CYC = 64;

   logic                  clk_i = 1'b0;
   logic                  rstn_i;
   logic [NREQ-1:0]       req_valid_i;
   logic [NREQ*NBITS-1:0] req_data_i;
   logic [NREQ-1:0]       req_ready_o;
   logic [NREQ-1:0]       rsp_valid_o;
   logic [NBITS-1:0]      rsp_data_o;
   logic                  rsp_err_o;
   logic [NREQ-1:0]       rsp_ready_i;
   logic                  sqrt_start_o;
   logic [NBITS-1:0]      sqrt_n_o;
   logic                  sqrt_busy_i;
   logic                  sqrt_valid_i;
   logic [NBITS-1:0]      sqrt_result_i;

   int checks   = 0;
   int failures = 0;
   int ptr_m    = 0;
   int starts   = 0;
   int stray_req  = 0;
   int stray_done = 0;
   bit withhold = 1'b0;

   sqrt_arbiter #(
      .NBITS       (NBITS),
      .NREQ        (NREQ),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .req_valid_i   (req_valid_i),
      .req_data_i    (req_data_i),
      .req_ready_o   (req_ready_o),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_data_o    (rsp_data_o),
      .rsp_err_o     (rsp_err_o),
      .rsp_ready_i   (rsp_ready_i),
      .sqrt_start_o  (sqrt_start_o),
      .sqrt_n_o      (sqrt_n_o),
      .sqrt_busy_i   (sqrt_busy_i),
      .sqrt_valid_i  (sqrt_valid_i),
      .sqrt_result_i (sqrt_result_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic int isqrt(input int n);
      int r = 0;
      while ((r + 1) * (r + 1) <= n) r++;
      return r;
   endfunction

   // Round-robin reference: first valid requester at or after the pointer.
   function automatic int pick(input logic [NREQ-1:0] v);
      for (int o = 0; o < NREQ; o++)
         if (v[(ptr_m + o) % NREQ]) return (ptr_m + o) % NREQ;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sqrt unit stand-in: answers each start pulse after a random delay.
   initial begin
      int pend_n;
      int delay;
      bit pending;
      pending = 1'b0; pend_n = 0; delay = 0;
      sqrt_valid_i = 1'b0; sqrt_result_i = '0;
      forever begin
         @(negedge clk_i);
         #2;
         sqrt_valid_i  = 1'b0;
         sqrt_result_i = '0;
         if (!rstn_i) begin
            pending = 1'b0;
         end else if (pending) begin
            if (delay > 0) delay--;
            else if (!withhold) begin
               sqrt_valid_i  = 1'b1;
               sqrt_result_i = NBITS'(isqrt(pend_n));
               pending       = 1'b0;
            end
         end else if (stray_req != stray_done) begin
            stray_done++;
            sqrt_valid_i  = 1'b1;
            sqrt_result_i = NBITS'($urandom_range(1, 31));
         end
         if (rstn_i && sqrt_start_o) begin
            starts++;
            pending = 1'b1;
            pend_n  = int'(sqrt_n_o);
            delay   = $urandom_range(0, 3);
         end
      end
   end

   task automatic apply_reset();
      rstn_i      = 1'b0;
      req_valid_i = '0;
      rsp_ready_i = '0;
      sqrt_busy_i = 1'b0;
      #1;
      check("reset_outputs", {req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, sqrt_start_o, sqrt_n_o}, 0);
      repeat (2) @(negedge clk_i);
      rstn_i = 1'b1;
      ptr_m  = 0;
   endtask

   // One full transaction from IDLE; called at a negedge with requests driven.
   task automatic transact(input int bp_cyc, input int busy_cyc, input bit hold, output int w_obs);
      logic [NREQ-1:0] oh;
      int w, n, cyc;
      bit got, leak, stable;
      w  = pick(req_valid_i);
      oh = NREQ'(1) << w;
      n  = int'(req_data_i[w*NBITS +: NBITS]);
      #1;
      w_obs = -1;
      for (int k = NREQ - 1; k >= 0; k--) if (req_ready_o[k]) w_obs = k;
      check("accept_ready", req_ready_o, oh);
      @(negedge clk_i);
      ptr_m = (w + 1) % NREQ;
      if (hold) req_data_i[w*NBITS +: NBITS] = NBITS'($urandom_range(0, 31));
      else      req_valid_i[w] = 1'b0;
      if (busy_cyc > 0) sqrt_busy_i = 1'b1;
      for (int i = 0; i < busy_cyc; i++) begin
         if (i > 0) @(negedge clk_i);
         #1 check("busy_no_start", sqrt_start_o, 0);
      end
      if (busy_cyc > 0) begin
         @(negedge clk_i);
         sqrt_busy_i = 1'b0;
      end
      #1;
      check("start_pulse", sqrt_start_o, 1);
      check("sqrt_operand", sqrt_n_o, n);
      got = 1'b0; leak = 1'b0;
      for (cyc = 0; cyc < 40 && !got; cyc++) begin
         @(negedge clk_i);
         #1;
         if (rsp_valid_o != '0) got = 1'b1;
         else if (req_ready_o != '0 || sqrt_start_o) leak = 1'b1;
      end
      check("rsp_timely", got, 1);
      check("no_ready_or_restart_in_wait", leak, 0);
      check("rsp_valid", rsp_valid_o, oh);
      check("rsp_data", rsp_data_o, isqrt(n));
      check("rsp_err", rsp_err_o, 0);
      stable = 1'b1;
      for (int i = 0; i < bp_cyc; i++) begin
         rsp_ready_i = ~oh;
         @(negedge clk_i);
         #1;
         if (rsp_valid_o !== oh || rsp_data_o !== NBITS'(isqrt(n)) || req_ready_o !== '0)
            stable = 1'b0;
      end
      if (bp_cyc > 0) check("backpressure_stable", stable, 1);
      rsp_ready_i = oh;
      @(negedge clk_i);
      rsp_ready_i = '0;
      #1;
      check("rsp_done_valid", rsp_valid_o, 0);
      check("rsp_done_data", rsp_data_o, 0);
   endtask

   initial begin
      int w, prev, s0;
      bit seen;
      #200000;
      $display("FAIL global_timeout observed=stuck expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int w, prev, s0, cyc;
      bit seen, got;
      req_data_i  = '0;
      sqrt_busy_i = 1'b0;
      apply_reset();

      // Single request, then prove the pointer moved to 1.
      req_data_i[0*NBITS +: NBITS] = 5'd16;
      req_valid_i = 4'b0001;
      s0 = starts;
      transact(0, 0, 0, w);
      check("single_grant", w, 0);
      req_valid_i = 4'b0011;
      req_data_i[1*NBITS +: NBITS] = 5'd30;
      transact(0, 0, 0, w);
      check("ptr_after_single", w, 1);
      transact(0, 0, 0, w);
      check("remaining_req0", w, 0);
      check("three_starts", starts - s0, 3);

      // Simultaneous requests 0 and 2 from pointer 0.
      apply_reset();
      req_data_i[0*NBITS +: NBITS] = 5'd9;
      req_data_i[2*NBITS +: NBITS] = 5'd25;
      req_valid_i = 4'b0101;
      s0 = starts;
      transact(0, 0, 0, w);
      check("simul_first", w, 0);
      transact(0, 0, 0, w);
      check("simul_second", w, 2);
      check("two_starts", starts - s0, 2);

      // All four held valid for 8 grants.
      apply_reset();
      for (int k = 0; k < NREQ; k++) req_data_i[k*NBITS +: NBITS] = NBITS'($urandom_range(0, 31));
      req_valid_i = 4'b1111;
      prev = -1;
      for (int g = 0; g < 8; g++) begin
         transact(0, 0, 1, w);
         check("rr_order", w, g % NREQ);
         if (g > 0) check("no_repeat_grant", (w == prev), 0);
         prev = w;
      end
      req_valid_i = '0;

      // Response backpressure on requester 1.
      req_data_i[1*NBITS +: NBITS] = NBITS'($urandom_range(0, 31));
      req_valid_i = 4'b0010;
      transact(5, 0, 0, w);
      check("bp_grant", w, 1);

      // Busy sqrt unit for 3 cycles in LAUNCH.
      req_data_i[2*NBITS +: NBITS] = NBITS'($urandom_range(0, 31));
      req_valid_i = 4'b0100;
      s0 = starts;
      transact(0, 3, 0, w);
      check("busy_single_start", starts - s0, 1);

      // Stray sqrt_valid_i while idle.
      s0 = starts;
      stray_req++;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk_i);
         #1;
         if (rsp_valid_o != '0 || sqrt_start_o) seen = 1'b1;
      end
      check("stray_ignored", seen, 0);
      check("stray_no_start", starts - s0, 0);

      // Randomised traffic against the reference model.
      for (int r = 0; r < 6; r++) begin
         @(negedge clk_i);
         for (int k = 0; k < NREQ; k++) req_data_i[k*NBITS +: NBITS] = NBITS'($urandom_range(0, 31));
         req_valid_i = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         while (req_valid_i != '0)
            transact($urandom_range(0, 2), $urandom_range(0, 2), 0, w);
      end

      // Reset asserted mid-WAIT, then a clean request 3 with N=4.
      apply_reset();
      withhold = 1'b1;
      req_data_i[3*NBITS +: NBITS] = NBITS'($urandom_range(0, 31));
      req_valid_i = 4'b1000;
      #1 check("mid_reset_accept", req_ready_o, 4'b1000);
      @(negedge clk_i);
      req_valid_i = 4'b0001;
      #1 check("mid_reset_start", sqrt_start_o, 1);
      @(negedge clk_i);
      #3;
      rstn_i = 1'b0;
      #1;
      check("async_reset_outputs", {req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, sqrt_start_o, sqrt_n_o}, 0);
      repeat (2) @(negedge clk_i);
      rstn_i   = 1'b1;
      ptr_m    = 0;
      withhold = 1'b0;
      req_data_i[3*NBITS +: NBITS] = 5'd4;
      req_valid_i = 4'b1000;
      transact(0, 0, 0, w);
      check("post_reset_grant", w, 3);

`ifdef SQRT_ARB_TIMEOUT_EN
      // Withheld sqrt result triggers the watchdog.
      apply_reset();
      withhold = 1'b1;
      req_data_i[1*NBITS +: NBITS] = 5'd25;
      req_valid_i = 4'b0010;
      #1 check("to_accept", req_ready_o, 4'b0010);
      @(negedge clk_i);
      req_valid_i = '0;
      #1 check("to_start", sqrt_start_o, 1);
      got = 1'b0;
      for (cyc = 0; cyc < TIMEOUT_CYC + 10 && !got; cyc++) begin
         @(negedge clk_i);
         #1;
         if (rsp_valid_o != '0) got = 1'b1;
      end
      check("to_fired", got, 1);
      check("to_not_early", (cyc > TIMEOUT_CYC), 1);
      check("to_valid", rsp_valid_o, 4'b0010);
      check("to_err", rsp_err_o, 1);
      check("to_data", rsp_data_o, 0);
      rsp_ready_i = 4'b0010;
      @(negedge clk_i);
      rsp_ready_i = '0;
      #1 check("to_err_cleared", rsp_err_o, 0);
      apply_reset();
      withhold = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares one sqrt datapath instance between NREQ requesters.
- Each requester has a valid/ready request channel (operand) and a valid/ready response channel (result).
- Round-robin arbitration; one operation in flight at a time.
- Drives the sqrt unit's start/N inputs and collects its valid/result outputs; sits between the client blocks and the sqrt instance.

Parameters:
- NBITS, 5, operand/result width; must match the sqrt instance.
- NREQ, 4, number of requesters, 2..8.
- TIMEOUT_CYC, 64, watchdog limit in cycles; used only with SQRT_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NREQ  per-requester request valid.
- req_data_i  in  NREQ*NBITS  operands; requester k uses bits [k*NBITS +: NBITS].
- req_ready_o  out  NREQ  one-hot accept.
- rsp_valid_o  out  NREQ  one-hot response valid to the owning requester.
- rsp_data_o  out  NBITS  result, shared by all requesters.
- rsp_err_o  out  1  result invalid (timeout); constant 0 without the macro.
- rsp_ready_i  in  NREQ  per-requester response ready.
- sqrt_start_o  out  1  start pulse to the sqrt unit.
- sqrt_n_o  out  NBITS  operand to the sqrt unit.
- sqrt_busy_i  in  1  sqrt unit busy.
- sqrt_valid_i  in  1  sqrt result valid (pulse).
- sqrt_result_i  in  NBITS  sqrt result.

Behaviour:
- Reset (async, rstn_i low):
  - State IDLE; rr pointer 0; grant index 0; operand and result registers 0.
  - All outputs 0.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req_valid_i is set, the winner is the first set bit at or after the rr pointer, wrapping modulo NREQ.
  - req_ready_o[winner]=1 combinationally in the same cycle; all other ready bits are 0.
  - On that edge: latch the operand and the grant index, set rr pointer to winner+1 (wrapping NREQ-1 to 0), go to LAUNCH.
  - req_ready_o is 0 in every other state.
- LAUNCH:
  - If sqrt_busy_i=0, assert sqrt_start_o for exactly one cycle and go to WAIT.
  - If sqrt_busy_i=1, hold sqrt_start_o=0 and stay in LAUNCH.
  - sqrt_n_o = latched operand from LAUNCH through WAIT; 0 otherwise.
- WAIT:
  - On sqrt_valid_i=1, latch sqrt_result_i and go to RESP.
  - sqrt_valid_i seen in IDLE, LAUNCH or RESP is ignored (stray pulse).
- RESP:
  - rsp_valid_o[grant]=1; rsp_data_o = latched result.
  - Stay until rsp_ready_i[grant]=1, then go to IDLE with rsp_valid_o=0 the next cycle.
  - rsp_ready_i bits of other requesters are ignored.
  - rsp_data_o is 0 when rsp_valid_o=0.
- Latency: request accept (cycle 0) → start pulse at cycle 1 if not busy → response valid 1 cycle after sqrt_valid_i.
- Throughput: the earliest re-accept is the cycle after the response handshake.
- Simultaneous events:
  - A new request arriving during LAUNCH/WAIT/RESP is held by the requester; it is not dropped.
  - The pointer advances only on acceptance, so a starved requester is served within NREQ grants.
- Reset mid-operation: the FSM aborts to IDLE and any in-flight result is discarded. The sqrt unit is reset by the same rstn_i, so its state stays coherent.
- Protocol assumption: requesters hold req_valid_i/req_data_i stable until ready. Data changing before ready is a requester protocol error; the arbiter only latches on accept.

Optional Feature:
- Macro: SQRT_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT.
  - If it reaches TIMEOUT_CYC without sqrt_valid_i, go to RESP with result 0 and rsp_err_o=1 for that response.
  - rsp_err_o is cleared with rsp_valid_o.
  - Counter width is $clog2(TIMEOUT_CYC+1).
- Undefined:
  - No counter; rsp_err_o tied 0.
  - WAIT lasts until sqrt_valid_i, indefinitely.

Decomposition:
- Shared package sqrt_pkg holds:
  - the state enum typedef (IDLE, LAUNCH, WAIT, RESP);
  - localparam IDXW = $clog2(NREQ) derivation helper;
  - default NBITS.
- Natural sub-module: rr_arbiter. Inputs: request vector, pointer. Outputs: one-hot grant and index. Purely combinational, reusable.
- The FSM, registers and watchdog stay in sqrt_arbiter.

Test Plan:
- Single request: req 0 with N=16 → req_ready_o=0001 the same cycle; one start pulse; rsp_valid_o=0001, rsp_data_o=4; pointer=1.
- Simultaneous req 0 (N=9) and req 2 (N=25), pointer 0 → serve 0 first (rsp 3), then 2 (rsp 5); exactly two start pulses.
- All four requesters held valid for 8 grants → grant order 0,1,2,3,0,1,2,3; no requester is granted twice in a row.
- Response backpressure: rsp_ready_i[1]=0 for 5 cycles after rsp_valid_o[1] rises → rsp_valid_o and rsp_data_o stay stable; no req_ready_o while waiting; release completes the handshake.
- sqrt_busy_i forced high for 3 cycles in LAUNCH → sqrt_start_o stays 0 for those cycles, then a single pulse. A stray sqrt_valid_i in IDLE produces no response.
- Reset asserted mid-WAIT → all outputs 0 asynchronously; after release, a req 3 with N=4 yields rsp 2. With SQRT_ARB_TIMEOUT_EN and sqrt_valid_i withheld → rsp_err_o=1 with rsp_data_o=0 after TIMEOUT_CYC cycles.
